exception_ctrl: RTL and testbench
=================================

// Module: exception_ctrl
// PURPOSE
//  Collects exception requests from the IF/ID/EX/MEM stages and selects the oldest one.
//  Freezes and flushes the pipeline, waits for the store buffer to drain, then presents
//  one single-cycle exception record to the privileged register file (rm0-rm4).
//  Sits directly upstream of privileged_regs and drives its exception/fault inputs.
// PARAMETERS
//  DRAIN_CYCLES  2   minimum cycles spent in DRAIN before RAISE (>=1)
//  CNT_W         16  width of the raised-exception counter (EXC_COUNT_EN only)
// PORTS
//  clk                 in   1   clock
//  reset               in   1   asynchronous, active-high reset
//  in_if_exc           in   3   IF exception code, 0 = none
//  in_if_pc            in   32  IF pc
//  in_id_exc           in   3   ID exception code (illegal instr, etc.)
//  in_id_pc            in   32  ID pc
//  in_id_instr         in   32  ID instruction word
//  in_ex_exc           in   3   EX exception code
//  in_ex_pc            in   32  EX pc
//  in_mem_exc          in   3   MEM exception code (dtlb miss, misaligned)
//  in_mem_pc           in   32  MEM pc
//  in_mem_addr         in   32  MEM faulting data address
//  in_sb_empty         in   1   store buffer empty
//  out_stall           out  1   freeze all pipeline stage registers
//  out_flush           out  1   kill IF..EX stage contents
//  out_exception_vector out 3   to privileged_regs; nonzero only in RAISE
//  out_fault_pc        out  32  to privileged_regs (rm0)
//  out_fault_addr      out  32  to privileged_regs (rm1)
//  out_additional_info out  32  to privileged_regs (rm2)
//  out_exc_count       out  CNT_W  exceptions raised since reset
// BEHAVIOUR
//  - Reset (async): state=IDLE; every output 0; latched record, stage tag, drain counter 0.
//  - Priority: MEM(3) > EX(2) > ID(1) > IF(0); oldest stage with nonzero code wins.
//  - Record per stage:
//    - IF: addr=pc, info=0.
//    - ID: addr=pc, info=instr.
//    - EX: addr=pc, info=0.
//    - MEM: addr=mem_addr, info=0.
//  - States:
//    - IDLE:
//      - any code!=0 -> latch code/pc/addr/info plus stage tag, counter<=0 -> DRAIN.
//    - DRAIN:
//      - stall=1, flush=1; counter increments, saturating at DRAIN_CYCLES.
//      - New code from a stage strictly older than the tag -> replace record and tag,
//        counter<=0.
//      - Codes from same or younger stages are ignored.
//      - counter==DRAIN_CYCLES && in_sb_empty -> RAISE.
//    - RAISE (exactly 1 cycle):
//      - stall=1, flush=1.
//      - out_exception_vector/fault_pc/fault_addr/additional_info = latched record.
//      - New stage inputs are ignored -> HOLD.
//    - HOLD (1 cycle):
//      - flush=1, stall=0, record outputs 0; kills the wrong-path fetch while the PC
//        redirect to 0x2000 lands.
//      - -> IDLE. Inputs are not sampled in HOLD.
//  - Outputs are registered and are decoded from the current state.
//    - Latency: an exception seen in IDLE at cycle N gives stall/flush at N+1.
//    - RAISE occurs no earlier than cycle N+1+DRAIN_CYCLES.
//  - in_sb_empty=0 holds DRAIN indefinitely. There is no timeout.
//  - Reset asserted in any state returns to IDLE immediately; a pending record is
//    discarded and not raised.
//  - Exception codes pass through unmodified; the 3-bit code space is owned by the
//    privileged unit.
// CONFIGURATION
//  EXC_COUNT_EN defined:
//    - out_exc_count increments by 1 on each RAISE cycle.
//    - Saturates at 2^CNT_W-1; cleared by reset.
//  EXC_COUNT_EN undefined:
//    - Counter logic is removed; out_exc_count is tied to 0.
// TESTING
//  - Single ID illegal: in_id_exc=3, pc=0x40, instr=0xFFFFFFFF for 1 cycle, sb_empty=1,
//    DRAIN_CYCLES=2.
//    -> stall/flush rise next cycle.
//    -> RAISE 3 cycles after input: vector=3, fault_pc=0x40, addr=0x40, info=0xFFFFFFFF.
//    -> HOLD, then IDLE.
//  - Simultaneous: IF code 1 (pc 0x80) and MEM code 2 (pc 0x70, addr 0x1234), same cycle.
//    -> RAISE carries vector=2, pc=0x70, addr=0x1234.
//  - Older replaces younger: EX code 4 latched, then MEM code 2 on the 2nd DRAIN cycle.
//    -> record switches to MEM and the counter restarts.
//    -> RAISE is 2 cycles after the replacement, with vector=2.
//  - Younger ignored: MEM latched, then ID code 3 during DRAIN.
//    -> record is unchanged.
//  - Store drain: sb_empty=0 for 10 cycles.
//    -> DRAIN is held and vector stays 0.
//    -> RAISE occurs on the cycle after sb_empty rises.
//  - Async reset mid-DRAIN, and counter:
//    -> All outputs 0 with no clock edge; no RAISE follows.
//    -> With EXC_COUNT_EN, 3 raised exceptions -> out_exc_count=3; without it, 0.

Source files
------------

// File: rtl/exception_ctrl.sv
// exception_ctrl: picks the oldest pipeline exception (MEM > EX > ID > IF), freezes and
// flushes the pipeline, waits for the store buffer to drain, then presents one single-cycle
// exception record to privileged_regs, followed by one flush-only HOLD cycle.
// Optional build macro EXC_COUNT_EN: enables out_exc_count (saturating count of RAISE cycles);
// without it the counter is removed and out_exc_count is tied to 0.
// Ports:
//   clk, reset (async, active-high)
//   in_{if,id,ex,mem}_exc / _pc      per-stage exception code (0 = none) and pc
//   in_id_instr, in_mem_addr         extra record fields for ID and MEM
//   in_sb_empty                      store buffer empty; holds DRAIN while low
//   out_stall, out_flush             pipeline freeze / kill IF..EX
//   out_exception_vector, out_fault_pc, out_fault_addr, out_additional_info
//                                    exception record, nonzero only in RAISE
//   out_exc_count                    exceptions raised since reset
module exception_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       in_if_exc,
  input  logic [31:0]      in_if_pc,
  input  logic [2:0]       in_id_exc,
  input  logic [31:0]      in_id_pc,
  input  logic [31:0]      in_id_instr,
  input  logic [2:0]       in_ex_exc,
  input  logic [31:0]      in_ex_pc,
  input  logic [2:0]       in_mem_exc,
  input  logic [31:0]      in_mem_pc,
  input  logic [31:0]      in_mem_addr,
  input  logic             in_sb_empty,
  output logic             out_stall,
  output logic             out_flush,
  output logic [2:0]       out_exception_vector,
  output logic [31:0]      out_fault_pc,
  output logic [31:0]      out_fault_addr,
  output logic [31:0]      out_additional_info,
  output logic [CNT_W-1:0] out_exc_count
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_MAX = DW'(DRAIN_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_RAISE, S_HOLD} state_t;

  state_t        r_state;
  logic [1:0]    r_tag;        // stage of the latched record: 3=MEM .. 0=IF
  logic [DW-1:0] r_drain_cnt;
  logic [2:0]    r_code;
  logic [31:0]   r_pc;
  logic [31:0]   r_addr;
  logic [31:0]   r_info;

  logic          w_any;
  logic [1:0]    w_sel;
  logic [2:0]    w_code;
  logic [31:0]   w_pc;
  logic [31:0]   w_addr;
  logic [31:0]   w_info;
  logic          w_latch;
  logic [DW-1:0] w_cnt_inc;

  // Oldest stage with a nonzero code and the record it would contribute.
  always_comb begin
    w_any  = 1'b1;
    w_sel  = 2'd0;
    w_code = 3'd0;
    w_pc   = 32'd0;
    w_addr = 32'd0;
    w_info = 32'd0;
    if (in_mem_exc != 3'd0) begin
      w_sel  = 2'd3;
      w_code = in_mem_exc;
      w_pc   = in_mem_pc;
      w_addr = in_mem_addr;
    end else if (in_ex_exc != 3'd0) begin
      w_sel  = 2'd2;
      w_code = in_ex_exc;
      w_pc   = in_ex_pc;
      w_addr = in_ex_pc;
    end else if (in_id_exc != 3'd0) begin
      w_sel  = 2'd1;
      w_code = in_id_exc;
      w_pc   = in_id_pc;
      w_addr = in_id_pc;
      w_info = in_id_instr;
    end else if (in_if_exc != 3'd0) begin
      w_sel  = 2'd0;
      w_code = in_if_exc;
      w_pc   = in_if_pc;
      w_addr = in_if_pc;
    end else begin
      w_any  = 1'b0;
    end
  end

  // A new record is taken in IDLE, or in DRAIN only from a strictly older stage.
  assign w_latch = w_any && ((r_state == S_IDLE) ||
                             ((r_state == S_DRAIN) && (w_sel > r_tag)));

  assign w_cnt_inc = (r_drain_cnt == DRAIN_MAX) ? r_drain_cnt : r_drain_cnt + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tag  <= 2'd0;
      r_code <= 3'd0;
      r_pc   <= 32'd0;
      r_addr <= 32'd0;
      r_info <= 32'd0;
    end else if (w_latch) begin
      r_tag  <= w_sel;
      r_code <= w_code;
      r_pc   <= w_pc;
      r_addr <= w_addr;
      r_info <= w_info;
    end
  end

  // Outputs are registered from the state being entered, so they track r_state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state              <= S_IDLE;
      r_drain_cnt          <= '0;
      out_stall            <= 1'b0;
      out_flush            <= 1'b0;
      out_exception_vector <= 3'd0;
      out_fault_pc         <= 32'd0;
      out_fault_addr       <= 32'd0;
      out_additional_info  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= '0;
            out_stall   <= 1'b1;
            out_flush   <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_latch) begin
            // Older exception restarts the drain window.
            r_drain_cnt <= '0;
          end else if ((w_cnt_inc == DRAIN_MAX) && in_sb_empty) begin
            r_state              <= S_RAISE;
            r_drain_cnt          <= w_cnt_inc;
            out_exception_vector <= r_code;
            out_fault_pc         <= r_pc;
            out_fault_addr       <= r_addr;
            out_additional_info  <= r_info;
          end else begin
            r_drain_cnt <= w_cnt_inc;
          end
        end
        S_RAISE: begin
          r_state              <= S_HOLD;
          out_stall            <= 1'b0;
          out_exception_vector <= 3'd0;
          out_fault_pc         <= 32'd0;
          out_fault_addr       <= 32'd0;
          out_additional_info  <= 32'd0;
        end
        S_HOLD: begin
          r_state   <= S_IDLE;
          out_flush <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          out_stall <= 1'b0;
          out_flush <= 1'b0;
        end
      endcase
    end
  end

`ifdef EXC_COUNT_EN
  logic [CNT_W-1:0] r_exc_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_exc_count <= '0;
    end else if ((r_state == S_RAISE) && (r_exc_count != {CNT_W{1'b1}})) begin
      r_exc_count <= r_exc_count + 1'b1;
    end
  end

  assign out_exc_count = r_exc_count;
`else
  assign out_exc_count = '0;
`endif

endmodule

// File: tb/tb_exception_ctrl.sv
module tb_exception_ctrl;

  localparam int DC = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    if_exc, id_exc, ex_exc, mem_exc;
  logic [31:0]   if_pc, id_pc, id_instr, ex_pc, mem_pc, mem_addr;
  logic          sb_empty;
  logic          stall, flush;
  logic [2:0]    vec;
  logic [31:0]   fpc, faddr, finfo;
  logic [CW-1:0] cnt;

  exception_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .in_if_exc(if_exc), .in_if_pc(if_pc),
    .in_id_exc(id_exc), .in_id_pc(id_pc), .in_id_instr(id_instr),
    .in_ex_exc(ex_exc), .in_ex_pc(ex_pc),
    .in_mem_exc(mem_exc), .in_mem_pc(mem_pc), .in_mem_addr(mem_addr),
    .in_sb_empty(sb_empty),
    .out_stall(stall), .out_flush(flush),
    .out_exception_vector(vec), .out_fault_pc(fpc),
    .out_fault_addr(faddr), .out_additional_info(finfo),
    .out_exc_count(cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic expect32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a record is "pending" from the cycle it is taken; it is raised once
  // at least DC cycles have passed since it was (re)taken and the store buffer is empty.
  int          cyc;
  int          t_latch;
  bit          m_pending, m_raise, m_hold;
  int          m_tag;
  logic [2:0]  m_code;
  logic [31:0] m_pc, m_addr, m_info;
  int          m_cnt;

  task automatic model_reset();
    cyc = 0; t_latch = 0;
    m_pending = 0; m_raise = 0; m_hold = 0;
    m_tag = 0; m_code = 0; m_pc = 0; m_addr = 0; m_info = 0;
    m_cnt = 0;
  endtask

  task automatic model_step();
    logic [2:0]  c[4];
    logic [31:0] p[4], a[4], f[4];
    int s;
    if (reset) begin
      model_reset();
      return;
    end
    cyc++;
    c = '{if_exc, id_exc, ex_exc, mem_exc};
    p = '{if_pc, id_pc, ex_pc, mem_pc};
    a = '{if_pc, id_pc, ex_pc, mem_addr};
    f = '{32'd0, id_instr, 32'd0, 32'd0};
    s = -1;
    for (int k = 0; k < 4; k++) if (c[k] != 3'd0) s = k;
    if (m_hold) begin
      m_hold = 0;
    end else if (m_raise) begin
      m_raise = 0;
      m_hold  = 1;
      if (m_cnt != (1 << CW) - 1) m_cnt++;
    end else if ((s >= 0) && (!m_pending || s > m_tag)) begin
      m_pending = 1; m_tag = s; t_latch = cyc;
      m_code = c[s]; m_pc = p[s]; m_addr = a[s]; m_info = f[s];
    end else if (m_pending && (cyc - t_latch >= DC) && sb_empty) begin
      m_pending = 0;
      m_raise   = 1;
    end
  endtask

  task automatic compare();
    int ecnt;
`ifdef EXC_COUNT_EN
    ecnt = m_cnt;
`else
    ecnt = 0;
`endif
    expect32("cyc_stall", 32'(stall), 32'(m_pending || m_raise));
    expect32("cyc_flush", 32'(flush), 32'(m_pending || m_raise || m_hold));
    expect32("cyc_vector", 32'(vec), m_raise ? 32'(m_code) : 32'd0);
    expect32("cyc_fault_pc", fpc, m_raise ? m_pc : 32'd0);
    expect32("cyc_fault_addr", faddr, m_raise ? m_addr : 32'd0);
    expect32("cyc_info", finfo, m_raise ? m_info : 32'd0);
    expect32("cyc_count", 32'(cnt), 32'(ecnt));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic clear_inputs();
    if_exc = 0; id_exc = 0; ex_exc = 0; mem_exc = 0;
    if_pc = 0; id_pc = 0; id_instr = 0; ex_pc = 0; mem_pc = 0; mem_addr = 0;
    sb_empty = 1;
  endtask

  // Reset asserted between edges; outputs must clear with no clock edge.
  task automatic async_reset_pulse(input string name);
    reset = 1;
    #1;
    expect32({name, "_stall"}, 32'(stall), 32'd0);
    expect32({name, "_flush"}, 32'(flush), 32'd0);
    expect32({name, "_vector"}, 32'(vec), 32'd0);
    expect32({name, "_count"}, 32'(cnt), 32'd0);
    model_reset();
    #1;
    reset = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    model_reset();
    #2;
    expect32("reset_stall", 32'(stall), 32'd0);
    expect32("reset_flush", 32'(flush), 32'd0);
    expect32("reset_vector", 32'(vec), 32'd0);
    expect32("reset_fault_pc", fpc, 32'd0);
    expect32("reset_count", 32'(cnt), 32'd0);
    ticks(2);
    reset = 0;
    ticks(2);

    // Single ID illegal instruction.
    id_exc = 3; id_pc = 32'h40; id_instr = 32'hFFFF_FFFF;
    tick();
    clear_inputs();
    expect32("id_stall_next", 32'(stall), 32'd1);
    expect32("id_flush_next", 32'(flush), 32'd1);
    tick();
    expect32("id_no_early_raise", 32'(vec), 32'd0);
    tick();
    expect32("id_vector", 32'(vec), 32'd3);
    expect32("id_fault_pc", fpc, 32'h40);
    expect32("id_fault_addr", faddr, 32'h40);
    expect32("id_info", finfo, 32'hFFFF_FFFF);
    tick();
    expect32("id_hold_flush", 32'(flush), 32'd1);
    expect32("id_hold_stall", 32'(stall), 32'd0);
    expect32("id_hold_vector", 32'(vec), 32'd0);
    tick();
    expect32("id_idle_flush", 32'(flush), 32'd0);

    // Simultaneous IF and MEM: MEM wins.
    if_exc = 1; if_pc = 32'h80; mem_exc = 2; mem_pc = 32'h70; mem_addr = 32'h1234;
    tick();
    clear_inputs();
    ticks(2);
    expect32("sim_vector", 32'(vec), 32'd2);
    expect32("sim_fault_pc", fpc, 32'h70);
    expect32("sim_fault_addr", faddr, 32'h1234);
    expect32("sim_info", finfo, 32'd0);
    ticks(2);

    // Older MEM replaces latched EX on the second DRAIN cycle.
    ex_exc = 4; ex_pc = 32'h100;
    tick();
    clear_inputs();
    tick();
    mem_exc = 2; mem_pc = 32'h200; mem_addr = 32'h300;
    tick();
    clear_inputs();
    expect32("repl_no_raise", 32'(vec), 32'd0);
    expect32("repl_stall", 32'(stall), 32'd1);
    tick();
    expect32("repl_no_raise2", 32'(vec), 32'd0);
    tick();
    expect32("repl_vector", 32'(vec), 32'd2);
    expect32("repl_fault_pc", fpc, 32'h200);
    expect32("repl_fault_addr", faddr, 32'h300);
    ticks(2);

    // Younger ID ignored while MEM record pending.
    mem_exc = 5; mem_pc = 32'h10; mem_addr = 32'h20;
    tick();
    clear_inputs();
    id_exc = 3; id_pc = 32'h44; id_instr = 32'h5;
    tick();
    clear_inputs();
    tick();
    expect32("young_vector", 32'(vec), 32'd5);
    expect32("young_fault_pc", fpc, 32'h10);
    expect32("young_fault_addr", faddr, 32'h20);
    expect32("young_info", finfo, 32'd0);
    ticks(2);

    // Store buffer not empty holds DRAIN.
    sb_empty = 0; ex_exc = 6; ex_pc = 32'h500;
    tick();
    ex_exc = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      expect32("sb_hold_vector", 32'(vec), 32'd0);
      expect32("sb_hold_stall", 32'(stall), 32'd1);
    end
    sb_empty = 1;
    tick();
    expect32("sb_vector", 32'(vec), 32'd6);
    expect32("sb_fault_pc", fpc, 32'h500);
    ticks(2);

    // Async reset mid-DRAIN discards the pending record.
    ex_exc = 1; ex_pc = 32'h600;
    tick();
    clear_inputs();
    expect32("ar_in_drain", 32'(stall), 32'd1);
    async_reset_pulse("ar");
    for (int i = 0; i < 5; i++) begin
      tick();
      expect32("ar_no_raise", 32'(vec), 32'd0);
    end

    // Raised-exception counter.
    async_reset_pulse("cnt_rst");
    for (int n = 0; n < 3; n++) begin
      ex_exc = 3'(n + 1); ex_pc = 32'h700 + 32'(n);
      tick();
      clear_inputs();
      ticks(5);
    end
`ifdef EXC_COUNT_EN
    expect32("count_three", 32'(cnt), 32'd3);
`else
    expect32("count_tied_zero", 32'(cnt), 32'd0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if_exc   = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      id_exc   = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      ex_exc   = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      mem_exc  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      if_pc    = $urandom; id_pc = $urandom; id_instr = $urandom;
      ex_pc    = $urandom; mem_pc = $urandom; mem_addr = $urandom;
      sb_empty = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) async_reset_pulse("rnd_rst");
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
